// File: rtl/core_pkg.sv
// Shared types and constants for the core control path: sequencer state
// encoding, the opcodes the sequencer cares about, and the instruction class.
package core_pkg;

  // Sequencer state; the encoding is visible on the debug stage output.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } seq_state_t;

  // Major opcodes (instr[6:0]) recognised by the sequencer.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Coarse instruction class used to pick the control path.
  typedef enum logic [1:0] {
    CLS_ALU     = 2'd0,
    CLS_SYSTEM  = 2'd1,
    CLS_ILLEGAL = 2'd2
  } instr_class_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode classifier: maps the major opcode and rd field to an
// instruction class plus a flag telling whether a register write is useful.
module op_classify
  import core_pkg::*;
(
  input  logic [6:0]   opcode,
  input  logic [4:0]   rd,
  output instr_class_t cls,
  output logic         wb_ok
);

  // Classify the opcode; writes to x0 are suppressed since x0 is hardwired.
  always_comb begin
    cls   = CLS_ILLEGAL;
    wb_ok = 1'b0;
    case (opcode)
      OPC_OP, OPC_OPIMM: begin
        cls   = CLS_ALU;
        wb_ok = (rd != 5'd0);
      end
      OPC_SYSTEM: cls = CLS_SYSTEM;
      default:    cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RV32I datapath. Steps every instruction
// through fetch/decode/execute/writeback, supports free-run and single-step,
// halts on SYSTEM or unsupported opcodes, and counts retired instructions.
module core_sequencer
  import core_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             step_req,
  input  logic [31:0]      instr_i,
  output logic             imem_rd,
  output logic             ir_en,
  output logic             alu_en,
  output logic             reg_write,
  output logic             pc_en,
  output logic [2:0]       stage,
  output logic             busy,
  output logic             step_done,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  // Last fetch-wait count before the instruction word is valid.
  localparam logic [1:0] WAIT_LAST = 2'(IMEM_LAT - 1);

  seq_state_t       state_reg, state_next;
  logic [1:0]       wait_cnt_reg, wait_cnt_next;
  logic             step_mode_reg, step_mode_next;
  logic             wb_ok_reg, wb_ok_next;
  logic             trap_reg, trap_next;
  logic [CNT_W-1:0] retired_reg, retired_next;

  instr_class_t     dec_cls;
  logic             dec_wb_ok;

  // Only opcode and rd matter here; the upper instruction bits belong to the datapath.
  logic             unused_instr_hi;
  assign unused_instr_hi = ^instr_i[31:12];

  op_classify u_op_classify (
    .opcode (instr_i[6:0]),
    .rd     (instr_i[11:7]),
    .cls    (dec_cls),
    .wb_ok  (dec_wb_ok)
  );

  // State and bookkeeping registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      wait_cnt_reg  <= 2'd0;
      step_mode_reg <= 1'b0;
      wb_ok_reg     <= 1'b0;
      trap_reg      <= 1'b0;
      retired_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      wait_cnt_reg  <= wait_cnt_next;
      step_mode_reg <= step_mode_next;
      wb_ok_reg     <= wb_ok_next;
      trap_reg      <= trap_next;
      retired_reg   <= retired_next;
    end
  end

  // Next-state logic and state-decoded datapath enables.
  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    step_mode_next = step_mode_reg;
    wb_ok_next     = wb_ok_reg;
    trap_next      = trap_reg;
    retired_next   = retired_reg;
    imem_rd        = 1'b0;
    ir_en          = 1'b0;
    alu_en         = 1'b0;
    reg_write      = 1'b0;
    pc_en          = 1'b0;
    step_done      = 1'b0;
    halted         = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // Run has priority over a coincident step request.
        if (run_i) begin
          state_next     = ST_FETCH;
          step_mode_next = 1'b0;
        end else if (step_req) begin
          state_next     = ST_FETCH;
          step_mode_next = 1'b1;
        end
      end

      ST_FETCH: begin
        imem_rd = 1'b1;
        if (wait_cnt_reg == WAIT_LAST) begin
          wait_cnt_next = 2'd0;
          state_next    = ST_DECODE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 2'd1;
        end
      end

      ST_DECODE: begin
        ir_en = 1'b1;
        case (dec_cls)
          CLS_ALU: begin
            wb_ok_next = dec_wb_ok;
            state_next = ST_EXECUTE;
          end
          CLS_SYSTEM: begin
            trap_next  = 1'b0;
            state_next = ST_HALT;
          end
          default: begin
            trap_next  = 1'b1;
            state_next = ST_HALT;
          end
        endcase
      end

      ST_EXECUTE: begin
        alu_en     = 1'b1;
        state_next = ST_WRITEBACK;
      end

      ST_WRITEBACK: begin
        reg_write    = wb_ok_reg;
        pc_en        = 1'b1;
        step_done    = step_mode_reg;
        retired_next = retired_reg + CNT_W'(1);
        if (step_mode_reg) begin
          step_mode_next = 1'b0;
          state_next     = ST_IDLE;
        end else if (run_i) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_IDLE;
        end
      end

      ST_HALT: begin
        // Absorbing: only reset leaves this state.
        halted = 1'b1;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign stage   = state_reg;
  assign busy    = (state_reg != ST_IDLE) && (state_reg != ST_HALT);
  assign trap    = trap_reg;
  assign retired = retired_reg;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: default-latency instance for the
// main scenarios plus an IMEM_LAT=3 instance for latency and wrap checks.
module tb_core_sequencer;

  typedef struct {
    logic        rw;
    logic        sd;
    logic [31:0] ret;
  } exp_t;

  exp_t sb_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  logic [31:0] exp_retired = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run_i = 1'b0, step_req = 1'b0;
  logic [31:0] instr_i = 32'd0;
  logic        imem_rd, ir_en, alu_en, reg_write, pc_en, busy, step_done, halted, trap;
  logic [2:0]  stage;
  logic [31:0] retired;

  logic        run3 = 1'b0, step3 = 1'b0;
  logic [31:0] instr3 = 32'd0;
  logic        imem_rd3, ir_en3, alu_en3, reg_write3, pc_en3, busy3, step_done3, halted3, trap3;
  logic [2:0]  stage3;
  logic [31:0] retired3;

  always #5 clk = ~clk;

  core_sequencer #(.IMEM_LAT(1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .step_req(step_req), .instr_i(instr_i),
    .imem_rd(imem_rd), .ir_en(ir_en), .alu_en(alu_en), .reg_write(reg_write),
    .pc_en(pc_en), .stage(stage), .busy(busy), .step_done(step_done),
    .halted(halted), .trap(trap), .retired(retired)
  );

  core_sequencer #(.IMEM_LAT(3), .CNT_W(32)) dut3 (
    .clk(clk), .rst_n(rst_n), .run_i(run3), .step_req(step3), .instr_i(instr3),
    .imem_rd(imem_rd3), .ir_en(ir_en3), .alu_en(alu_en3), .reg_write(reg_write3),
    .pc_en(pc_en3), .stage(stage3), .busy(busy3), .step_done(step_done3),
    .halted(halted3), .trap(trap3), .retired(retired3)
  );

  // Wait for a writeback on the selected instance, pop the expected entry
  // and compare latency, enables, the post-retire count and the next stage.
  task automatic wait_wb(input string name, input bit sel, input int exp_lat,
                         input logic [2:0] exp_stage_after);
    int          i;
    bit          seen;
    exp_t        e;
    logic        rw, sd;
    logic [31:0] ret;
    logic [2:0]  stg;
    seen = 1'b0; i = 0; rw = 1'b0; sd = 1'b0;
    while (!seen && i < exp_lat + 8) begin
      @(negedge clk);
      i++;
      step_req = 1'b0;
      step3    = 1'b0;
      if (sel ? pc_en3 : pc_en) begin
        seen = 1'b1;
        rw = sel ? reg_write3 : reg_write;
        sd = sel ? step_done3 : step_done;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_timeout: pc_en never seen within %0d cycles, required at cycle %0d", name, i, exp_lat);
    end
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s_scoreboard: queue empty, required one entry", name);
      return;
    end
    e = sb_q.pop_front();
    vectors++;
    if (i !== exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, i, exp_lat);
    end
    vectors++;
    if (rw !== e.rw) begin
      miscompares++;
      $display("FAIL %s_reg_write: got %b, required %b", name, rw, e.rw);
    end
    vectors++;
    if (sd !== e.sd) begin
      miscompares++;
      $display("FAIL %s_step_done: got %b, required %b", name, sd, e.sd);
    end
    @(negedge clk);
    ret = sel ? retired3 : retired;
    stg = sel ? stage3 : stage;
    vectors++;
    if (ret !== e.ret) begin
      miscompares++;
      $display("FAIL %s_retired: got %h, required %h", name, ret, e.ret);
    end
    vectors++;
    if (stg !== exp_stage_after) begin
      miscompares++;
      $display("FAIL %s_stage_after: got %0d, required %0d", name, stg, exp_stage_after);
    end
    $display("txn %s: latency=%0d reg_write=%b step_done=%b retired=%h", name, i, rw, sd, ret);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run_i = 1'b0; step_req = 1'b0; run3 = 1'b0; step3 = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({imem_rd, ir_en, alu_en, reg_write, pc_en, stage, busy, step_done, halted, trap} !== 13'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {imem_rd, ir_en, alu_en, reg_write, pc_en, stage, busy, step_done, halted, trap});
    end
    vectors++;
    if (retired !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_retired: got %h, required 0", retired);
    end
    vectors++;
    if ({imem_rd3, pc_en3, stage3, busy3, halted3, trap3} !== 8'd0 || retired3 !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_dut3: got stage=%0d retired=%h, required 0/0", stage3, retired3);
    end
    rst_n = 1'b1;
    exp_retired = 32'd0;
    $display("txn reset: outputs idle");
  endtask

  task automatic test_step(input string name, input logic [31:0] instr, input logic exp_rw);
    @(negedge clk);
    instr_i = instr;
    exp_retired = exp_retired + 32'd1;
    sb_q.push_back('{rw: exp_rw, sd: 1'b1, ret: exp_retired});
    step_req = 1'b1;
    wait_wb(name, 1'b0, 4, 3'd0);
  endtask

  task automatic test_run_stream();
    int   n, i;
    int   pc_cyc[3];
    bit   busy_bad, sd_seen;
    exp_t e;
    n = 0; busy_bad = 1'b0; sd_seen = 1'b0;
    pc_cyc[0] = 0; pc_cyc[1] = 0; pc_cyc[2] = 0;
    @(negedge clk);
    instr_i = 32'h002081B3;
    for (int k = 1; k <= 3; k++) sb_q.push_back('{rw: 1'b1, sd: 1'b0, ret: exp_retired + 32'(k)});
    run_i = 1'b1;
    i = 0;
    while (n < 3 && i < 20) begin
      @(negedge clk);
      i++;
      if (!busy) busy_bad = 1'b1;
      if (step_done) sd_seen = 1'b1;
      if (pc_en) begin
        pc_cyc[n] = i;
        n++;
        e = sb_q.pop_front();
        vectors++;
        if (reg_write !== e.rw) begin
          miscompares++;
          $display("FAIL run_reg_write%0d: got %b, required %b", n, reg_write, e.rw);
        end
        $display("txn run_add%0d: cycle=%0d reg_write=%b step_done=%b", n, i, reg_write, step_done);
        if (n == 3) run_i = 1'b0;
      end
    end
    vectors++;
    if (pc_cyc[0] !== 4 || pc_cyc[1] !== 8 || pc_cyc[2] !== 12) begin
      miscompares++;
      $display("FAIL run_pc_spacing: got cycles %0d,%0d,%0d, required 4,8,12", pc_cyc[0], pc_cyc[1], pc_cyc[2]);
    end
    vectors++;
    if (busy_bad) begin
      miscompares++;
      $display("FAIL run_busy: got a low cycle, required continuously high");
    end
    vectors++;
    if (sd_seen) begin
      miscompares++;
      $display("FAIL run_step_done: got asserted, required never");
    end
    exp_retired = exp_retired + 32'd3;
    @(negedge clk);
    vectors++;
    if (retired !== exp_retired || stage !== 3'd0) begin
      miscompares++;
      $display("FAIL run_end: got retired=%h stage=%0d, required %h/0", retired, stage, exp_retired);
    end
  endtask

  task automatic test_halt(input string name, input logic [31:0] instr, input logic exp_trap);
    bit bad;
    @(negedge clk);
    instr_i = instr;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (ir_en !== 1'b1 || stage !== 3'd2) begin
      miscompares++;
      $display("FAIL %s_decode: got ir_en=%b stage=%0d, required 1/2", name, ir_en, stage);
    end
    @(negedge clk);
    vectors++;
    if (halted !== 1'b1 || trap !== exp_trap || busy !== 1'b0 || stage !== 3'd5) begin
      miscompares++;
      $display("FAIL %s_halt: got halted=%b trap=%b busy=%b stage=%0d, required 1/%b/0/5",
               name, halted, trap, busy, stage, exp_trap);
    end
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      run_i = ~run_i;
      step_req = k[0];
      @(negedge clk);
      if (pc_en || !halted || trap !== exp_trap) bad = 1'b1;
    end
    run_i = 1'b0; step_req = 1'b0;
    vectors++;
    if (bad || retired !== exp_retired) begin
      miscompares++;
      $display("FAIL %s_absorb: got retired=%h halted=%b, required %h/1", name, retired, halted, exp_retired);
    end
    $display("txn %s: halted=%b trap=%b retired=%h", name, halted, trap, retired);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_retired = 32'd0;
  endtask

  task automatic test_reset_mid();
    bit bad;
    @(negedge clk);
    instr_i = 32'h00500093;
    step_req = 1'b1;
    @(negedge clk);
    step_req = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (stage !== 3'd3 || alu_en !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_exec: got stage=%0d alu_en=%b, required 3/1", stage, alu_en);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({imem_rd, ir_en, alu_en, reg_write, pc_en, stage, busy, step_done, halted, trap} !== 13'd0
        || retired !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_async: got stage=%0d alu_en=%b busy=%b, required all zero", stage, alu_en, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (pc_en || reg_write || stage !== 3'd0) bad = 1'b1;
    end
    vectors++;
    if (bad || retired !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_nowb: got retired=%h, required 0 with no writeback", retired);
    end
    exp_retired = 32'd0;
    $display("txn midreset: stage=%0d retired=%h", stage, retired);
  endtask

  task automatic test_lat3_run_wins();
    int i, rd_cnt;
    bit seen, sd_seen;
    exp_t e;
    rd_cnt = 0; seen = 1'b0; sd_seen = 1'b0; i = 0;
    @(negedge clk);
    instr3 = 32'h002081B3;
    sb_q.push_back('{rw: 1'b1, sd: 1'b0, ret: 32'd1});
    run3 = 1'b1; step3 = 1'b1;
    while (!seen && i < 16) begin
      @(negedge clk);
      i++;
      step3 = 1'b0;
      if (imem_rd3) rd_cnt++;
      if (step_done3) sd_seen = 1'b1;
      if (pc_en3) begin
        seen = 1'b1;
        run3 = 1'b0;
        e = sb_q.pop_front();
        vectors++;
        if (reg_write3 !== e.rw) begin
          miscompares++;
          $display("FAIL lat3_reg_write: got %b, required %b", reg_write3, e.rw);
        end
      end
    end
    vectors++;
    if (!seen || i !== 6) begin
      miscompares++;
      $display("FAIL lat3_latency: got %0d cycles (seen=%b), required 6", i, seen);
    end
    vectors++;
    if (rd_cnt !== 3) begin
      miscompares++;
      $display("FAIL lat3_imem_rd: got %0d cycles, required 3", rd_cnt);
    end
    vectors++;
    if (sd_seen) begin
      miscompares++;
      $display("FAIL lat3_step_done: got asserted, required never in run mode");
    end
    @(negedge clk);
    vectors++;
    if (retired3 !== 32'd1 || stage3 !== 3'd0) begin
      miscompares++;
      $display("FAIL lat3_end: got retired=%h stage=%0d, required 1/0", retired3, stage3);
    end
    $display("txn lat3_run: latency=%0d imem_rd_cycles=%0d retired=%h", i, rd_cnt, retired3);
  endtask

  task automatic test_wrap();
    force dut3.retired_reg = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut3.retired_reg;
    @(negedge clk);
    vectors++;
    if (retired3 !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL wrap_preload: got %h, required ffffffff", retired3);
    end
    instr3 = 32'h00500093;
    sb_q.push_back('{rw: 1'b1, sd: 1'b1, ret: 32'd0});
    step3 = 1'b1;
    wait_wb("wrap_step", 1'b1, 6, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_step("step_addi", 32'h00500093, 1'b1);
    test_run_stream();
    test_step("nop_x0", 32'h00000013, 1'b0);
    test_halt("halt_ebreak", 32'h00100073, 1'b0);
    test_halt("halt_lw", 32'h0000A083, 1'b1);
    test_reset_mid();
    test_lat3_run_wins();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM that sequences the RV32I datapath (PC, instruction memory, register file, ALU) through fetch, decode, execute and writeback. It replaces hand-timed stimulus with cycle-exact enables. It also provides run/single-step control, halt on SYSTEM or unsupported opcodes, and a retired-instruction counter. It sits beside the datapath at core top level and drives every state-holding enable in it.

## Interface
- `IMEM_LAT`, default 1: instruction-memory read latency in cycles; legal values are 1..4.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk`  in  1  single core clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `run_i`  in  1  level; free-run enable.
- `step_req`  in  1  one-cycle pulse; executes exactly one instruction when the sequencer is idle.
- `instr_i`  in  32  instruction-memory read data.
- `imem_rd`  out  1  instruction-memory read strobe; PC is stable while this is high.
- `ir_en`  out  1  latch the instruction register and the ImmGen/decoder inputs.
- `alu_en`  out  1  latch operands and the ALU result register.
- `reg_write`  out  1  register-file write enable.
- `pc_en`  out  1  load PC with PC+4.
- `stage`  out  3  current state encoding, for debug.
- `busy`  out  1  high in any state other than IDLE and HALT.
- `step_done`  out  1  one-cycle pulse when a stepped instruction retires.
- `halted`  out  1  sequencer is in the HALT state.
- `trap`  out  1  halt was caused by an unsupported opcode.
- `retired`  out  CNT_W  count of retired instructions.

## Operation
- States are IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
- **IDLE**
  - `run_i`=1 → FETCH.
  - Otherwise `step_req`=1 → FETCH, and the internal `step_mode` flag is set.
  - If both are high, run wins and `step_mode` is cleared.
- **FETCH**
  - `imem_rd`=1 for IMEM_LAT cycles, counted by an internal wait counter. Then → DECODE.
- **DECODE**
  - `ir_en`=1.
  - `instr_i[6:0]` is classified:
    - 0110011 (OP) or 0010011 (OP-IMM): class ALU; `wb_ok` is latched as (`rd`≠0).
    - 1110011 (SYSTEM): → HALT with `trap`=0.
    - Anything else: → HALT with `trap`=1.
  - ALU class → EXECUTE.
- **EXECUTE**
  - `alu_en`=1. → WRITEBACK.
- **WRITEBACK**
  - `reg_write`=`wb_ok`.
  - `pc_en`=1.
  - `retired` increments.
  - `step_done`=`step_mode`.
  - Next state:
    - `step_mode`=1 → IDLE (clears `step_mode`).
    - Else `run_i`=1 → FETCH.
    - Else → IDLE.
- **HALT**
  - Absorbing state; exits only via `rst_n`.
  - PC is not advanced and `retired` is not incremented for the halting instruction.
- Enables are decoded from the state only. Every enable is 0 outside its own state.
- `step_req` is ignored outside IDLE and is never queued.
- `retired` wraps from 2^CNT_W−1 to 0 without any flag.

## Timing
- Reset values:
  - state=IDLE.
  - All enables 0.
  - `stage`=0, `busy`=0, `step_done`=0, `halted`=0, `trap`=0, `retired`=0.
  - `step_mode`=0, wait counter=0.
- Reset asserted mid-instruction:
  - All outputs go to their reset values immediately, asynchronously.
  - The datapath holds whatever it last latched.
  - No partial writeback occurs after reset assertion.
- Latency per instruction is IMEM_LAT+3 cycles (4 cycles at the default).
- Back-to-back execution in run mode: WRITEBACK is followed directly by FETCH, with no bubble.
- `run_i` is sampled only in IDLE and WRITEBACK. Deasserting it mid-instruction completes the current instruction, then the sequencer goes to IDLE.
- With `run_i`=1, `busy` stays high continuously.
- `step_done`, `reg_write` and `pc_en` are coincident, all within the single WRITEBACK cycle.
- `halted` rises the cycle after the DECODE that classified the instruction.

## Structure
- Shared package `core_pkg` holds:
  - The `seq_state_t` enum (3-bit encoding as above).
  - Opcode localparams `OPC_OP`, `OPC_OPIMM`, `OPC_SYSTEM`.
  - The instruction class enum.
- One sub-module, `op_classify`: combinational; maps `instr[6:0]` and `instr[11:7]` to {class, `wb_ok`}. The decoder will reuse it later.
- The FSM, wait counter and retire counter live in `core_sequencer`.

## Test plan
- Reset, then `step_req` pulse with `instr_i`=0x00500093 (`addi x1,x0,5`) → 4 cycles later a single cycle has `reg_write`=1, `pc_en`=1 and `step_done`=1; then IDLE, `retired`=1.
- `run_i`=1 with the stream `add x3,x1,x2` (0x002081B3) ×3 → `pc_en` pulses every 4 cycles, `busy` stays continuously high, `step_done` never asserts, `retired`=3.
- `instr_i`=0x00000013 (`addi x0,x0,0`) → `pc_en`=1, `reg_write`=0, `retired` increments.
- `instr_i`=0x00100073 (`ebreak`) → `halted`=1, `trap`=0, `pc_en` never asserts, `retired` unchanged; `run_i` toggling has no effect.
- `instr_i`=0x0000A083 (`lw`) → `halted`=1, `trap`=1. `rst_n` pulsed during EXECUTE of another instruction → all outputs 0 at once and `stage`=0.
- IMEM_LAT=3, `step_req` and `run_i` high in the same IDLE cycle → `imem_rd` high for 3 cycles, run mode taken, no `step_done`. With `retired` preloaded via force to 0xFFFFFFFF, one more retire → `retired` wraps to 0.
